encrypt_pipe_shift_rot: RTL and testbench

Rotate-and-encode stage of the encrypt shift pipe. It sits directly downstream of the data-compare stage and consumes that stage's enable, upper/lower-case flags and 26-bit one-hot letter vector. It applies a Caesar rotation by a registered key (fixed or progressive, encrypt or decrypt) and re-encodes the result to an ASCII byte. It adds two pipeline stages and never stalls.

---
 rtl/encrypt_pkg.sv | 36 +++
 rtl/encrypt_onehot_enc.sv | 24 ++
 rtl/encrypt_pipe_shift_rot.sv | 201 ++++++++++++++++++++
 tb/tb_encrypt_pipe_shift_rot.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/encrypt_pkg.sv
// Shared constants, stage-1 pipeline record and modular helpers for the
// rotate-and-encode stage of the encrypt shift pipe.
package encrypt_pkg;

    localparam int         ALPHA_N       = 26;
    localparam logic [7:0] ASCII_UPPER_A = 8'd65;
    localparam logic [7:0] ASCII_LOW_A   = 8'd97;
    localparam logic [7:0] ASCII_ERR     = 8'h3F;

    // Stage-1 record: rotated letter vector plus raw byte for pass-through.
    typedef struct packed {
        logic        valid;
        logic        upper;
        logic        low;
        logic        err;
        logic [25:0] onehot;
        logic [7:0]  raw;
    } stage1_t;

    // Add two residues in 0..25 and return the sum modulo 26.
    function automatic logic [4:0] mod26_add(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] sum_v;
        sum_v = {1'b0, a} + {1'b0, b};
        if (sum_v >= 6'(ALPHA_N)) begin
            return 5'(sum_v - 6'(ALPHA_N));
        end else begin
            return sum_v[4:0];
        end
    endfunction

    // True when exactly one bit of a 26-bit letter vector is set.
    function automatic logic is_onehot26(input logic [25:0] v);
        return (v != 26'd0) && ((v & (v - 26'd1)) == 26'd0);
    endfunction

endpackage

// File: rtl/encrypt_onehot_enc.sv
// Combinational 26-to-5 one-hot encoder. The index is the OR of the
// positions of all set bits, so it is only meaningful when onehot_ok is 1.
module encrypt_onehot_enc
    import encrypt_pkg::*;
(
    input  logic [25:0] onehot,
    output logic [4:0]  idx,
    output logic        onehot_ok
);

    logic [4:0] idx_s;

    // OR together the bit positions of every set bit.
    always_comb begin
        idx_s = 5'd0;
        for (int i = 0; i < ALPHA_N; i++) begin
            idx_s = idx_s | (onehot[i] ? 5'(i) : 5'd0);
        end
    end

    assign idx       = idx_s;
    assign onehot_ok = is_onehot26(onehot);

endmodule

// File: rtl/encrypt_pipe_shift_rot.sv
// Rotate-and-encode stage: Caesar-rotates the one-hot letter vector from the
// compare stage by a registered key (fixed or progressive, either direction)
// and re-encodes it to ASCII. Two register stages, no back-pressure.
module encrypt_pipe_shift_rot
    import encrypt_pkg::*;
#(
    parameter int KEY_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_in,
    input  logic             is_alpha_upper_case_in,
    input  logic             is_alpha_low_case_in,
    input  logic [25:0]      extended_shift_data_in,
    input  logic             dir,
    input  logic             key_load,
    input  logic [KEY_W-1:0] key_in,
    input  logic             prog,
    output logic             en_out,
    output logic [7:0]       dout,
    output logic             onehot_err_out
);

    logic [KEY_W-1:0] key_red_s;
    logic [4:0]       key_r;
    logic [4:0]       ofs_r;
    logic             one_flag_s;
    logic             both_flag_s;
    logic             vec_ok_s;
    logic             alpha_ok_s;
    logic             adv_s;
    logic [4:0]       k_s;
    logic [4:0]       rot_s;
    logic [25:0]      rot_opts_s [32];
    logic [25:0]      rotated_s;
    stage1_t          s1_next_s;
    stage1_t          s1_r;
    logic [4:0]       idx_s;
    logic             oh_ok_s;
    logic [7:0]       dout_next_s;
    logic             err_next_s;
    logic             en_out_r;
    logic [7:0]       dout_r;
    logic             err_r;

    // ---------------------------------------------------------------
    // Key and offset
    // ---------------------------------------------------------------
    assign one_flag_s  = is_alpha_upper_case_in ^ is_alpha_low_case_in;
    assign both_flag_s = is_alpha_upper_case_in & is_alpha_low_case_in;
    assign vec_ok_s    = is_onehot26(extended_shift_data_in);
    assign alpha_ok_s  = one_flag_s & vec_ok_s;
    // Only well-formed letters advance the progressive offset; malformed
    // characters leave the keystream where it was.
    assign adv_s       = prog & en_in & alpha_ok_s;

    // Fold an out-of-range key back into 0..25 before it is stored.
    always_comb begin
        key_red_s = key_in;
        if (key_in >= KEY_W'(ALPHA_N)) begin
            key_red_s = key_in - KEY_W'(ALPHA_N);
        end else begin
            key_red_s = key_in;
        end
    end

    // Key register: loaded on key_load, otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_r <= 5'd0;
        end else if (key_load) begin
            key_r <= key_red_s[4:0];
        end
    end

    // Progressive offset: cleared by a key load, which beats an advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ofs_r <= 5'd0;
        end else if (key_load) begin
            ofs_r <= 5'd0;
        end else if (adv_s) begin
            ofs_r <= mod26_add(ofs_r, 5'd1);
        end
    end

    // ---------------------------------------------------------------
    // Stage 1: rotate
    // ---------------------------------------------------------------
    assign k_s = mod26_add(key_r, ofs_r);

    // Decrypt rotates by the additive inverse of the effective key.
    always_comb begin
        rot_s = k_s;
        if (dir) begin
            rot_s = (k_s == 5'd0) ? 5'd0 : (5'(ALPHA_N) - k_s);
        end else begin
            rot_s = k_s;
        end
    end

    // Every left rotation of the 26-bit vector; selectors 26..31 alias
    // back onto 0..5 so the mux has no undefined legs.
    for (genvar r = 0; r < 32; r++) begin : g_rot
        localparam int SH = r % 26;
        assign rot_opts_s[r] = (extended_shift_data_in << SH)
                             | (extended_shift_data_in >> (26 - SH));
    end

    assign rotated_s = rot_opts_s[rot_s];

    // Assemble the stage-1 record from the current inputs.
    always_comb begin
        s1_next_s        = '0;
        s1_next_s.valid  = en_in;
        s1_next_s.upper  = is_alpha_upper_case_in;
        s1_next_s.low    = is_alpha_low_case_in;
        s1_next_s.err    = en_in & (both_flag_s | (one_flag_s & ~vec_ok_s));
        s1_next_s.onehot = rotated_s;
        s1_next_s.raw    = extended_shift_data_in[7:0];
    end

    // Stage-1 register: control always tracks en_in, data only on valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= '0;
        end else begin
            s1_r.valid <= s1_next_s.valid;
            s1_r.err   <= s1_next_s.err;
            if (en_in) begin
                s1_r.upper  <= s1_next_s.upper;
                s1_r.low    <= s1_next_s.low;
                s1_r.onehot <= s1_next_s.onehot;
                s1_r.raw    <= s1_next_s.raw;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: encode
    // ---------------------------------------------------------------
    encrypt_onehot_enc u_enc (
        .onehot    (s1_r.onehot),
        .idx       (idx_s),
        .onehot_ok (oh_ok_s)
    );

    // Map the rotated letter back to ASCII, or pass the raw byte through.
    always_comb begin
        dout_next_s = ASCII_ERR;
        err_next_s  = 1'b1;
        case ({s1_r.upper, s1_r.low})
            2'b10: begin
                if (s1_r.err || !oh_ok_s) begin
                    dout_next_s = ASCII_ERR;
                    err_next_s  = 1'b1;
                end else begin
                    dout_next_s = ASCII_UPPER_A + {3'b000, idx_s};
                    err_next_s  = 1'b0;
                end
            end
            2'b01: begin
                if (s1_r.err || !oh_ok_s) begin
                    dout_next_s = ASCII_ERR;
                    err_next_s  = 1'b1;
                end else begin
                    dout_next_s = ASCII_LOW_A + {3'b000, idx_s};
                    err_next_s  = 1'b0;
                end
            end
            2'b00: begin
                dout_next_s = s1_r.raw;
                err_next_s  = 1'b0;
            end
            default: begin
                dout_next_s = ASCII_ERR;
                err_next_s  = 1'b1;
            end
        endcase
    end

    // Output register: error flag is qualified by valid so it is 0 when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_out_r <= 1'b0;
            dout_r   <= 8'd0;
            err_r    <= 1'b0;
        end else begin
            en_out_r <= s1_r.valid;
            err_r    <= s1_r.valid & err_next_s;
            if (s1_r.valid) begin
                dout_r <= dout_next_s;
            end
        end
    end

    assign en_out         = en_out_r;
    assign dout           = dout_r;
    assign onehot_err_out = err_r;

endmodule

// File: tb/tb_encrypt_pipe_shift_rot.sv
// Scoreboard bench for encrypt_pipe_shift_rot: directed characters push
// hand-computed expectations; a negedge monitor pops and compares.
module tb_encrypt_pipe_shift_rot;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_in = 1'b0;
    logic        up = 1'b0;
    logic        lo = 1'b0;
    logic [25:0] data = 26'd0;
    logic        dir = 1'b0;
    logic        key_load = 1'b0;
    logic [4:0]  key_in = 5'd0;
    logic        prog = 1'b0;
    logic        en_out;
    logic [7:0]  dout;
    logic        onehot_err_out;

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    encrypt_pipe_shift_rot #(.KEY_W(5)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .en_in                  (en_in),
        .is_alpha_upper_case_in (up),
        .is_alpha_low_case_in   (lo),
        .extended_shift_data_in (data),
        .dir                    (dir),
        .key_load               (key_load),
        .key_in                 (key_in),
        .prog                   (prog),
        .en_out                 (en_out),
        .dout                   (dout),
        .onehot_err_out         (onehot_err_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop one expectation per valid output and compare.
    always @(negedge clk) begin
        if (!rst) begin
            if (en_out) begin
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_out: got dout=%h with empty scoreboard", dout);
                end else begin
                    mon_e = sb_q.pop_front();
                    vectors++;
                    if (dout !== mon_e.d || onehot_err_out !== mon_e.e || cyc != mon_e.cyc) begin
                        miscompares++;
                        $display("FAIL out_vec: got dout=%h err=%b cyc=%0d, want dout=%h err=%b cyc=%0d",
                                 dout, onehot_err_out, cyc, mon_e.d, mon_e.e, mon_e.cyc);
                    end
                end
            end else if (onehot_err_out !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_err: onehot_err_out=%b while en_out=0, want 0", onehot_err_out);
            end
        end
    end

    task automatic check_idle(input string name);
        vectors++;
        if (en_out !== 1'b0 || dout !== 8'd0 || onehot_err_out !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: en_out=%b dout=%h err=%b, want 0 00 0", name, en_out, dout, onehot_err_out);
        end
    endtask

    task automatic load_key(input logic [4:0] k);
        key_load = 1'b1;
        key_in   = k;
        @(posedge clk); #1;
        key_load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one character and push its expected encoding.
    task automatic send(input logic u, input logic l, input logic [25:0] d,
                        input logic kl, input logic [4:0] kv,
                        input logic [7:0] ed, input logic ee);
        exp_t x;
        en_in    = 1'b1;
        up       = u;
        lo       = l;
        data     = d;
        key_load = kl;
        key_in   = kv;
        x.d = ed; x.e = ee; x.cyc = cyc + 2;
        sb_q.push_back(x);
        @(posedge clk); #1;
        en_in    = 1'b0;
        key_load = 1'b0;
    endtask

    initial begin
        #22;
        check_idle("reset_state");
        rst = 1'b0;
        idle(1);

        // Decrypt with key 0 is the identity.
        dir = 1'b1;
        send(1'b1, 1'b0, 26'h1, 1'b0, 5'd0, 8'h41, 1'b0);
        // Encrypt A with key 3.
        dir = 1'b0;
        load_key(5'd3);
        send(1'b1, 1'b0, 26'h1, 1'b0, 5'd0, 8'h44, 1'b0);
        // z + 1 wraps to a.
        load_key(5'd1);
        send(1'b0, 1'b1, 26'h2000000, 1'b0, 5'd0, 8'h61, 1'b0);
        // a - 3 wraps to x.
        load_key(5'd3);
        dir = 1'b1;
        send(1'b0, 1'b1, 26'h1, 1'b0, 5'd0, 8'h78, 1'b0);
        dir = 1'b0;
        // Key 30 reduces to 4.
        load_key(5'd30);
        send(1'b1, 1'b0, 26'h1, 1'b0, 5'd0, 8'h45, 1'b0);
        // Non-alpha byte passes through.
        send(1'b0, 1'b0, 26'h35, 1'b0, 5'd0, 8'h35, 1'b0);

        // Progressive: B, C, D (reload with third), then B again.
        load_key(5'd1);
        prog = 1'b1;
        send(1'b1, 1'b0, 26'h1, 1'b0, 5'd0, 8'h42, 1'b0);
        send(1'b1, 1'b0, 26'h1, 1'b0, 5'd0, 8'h43, 1'b0);
        send(1'b1, 1'b0, 26'h1, 1'b1, 5'd1, 8'h44, 1'b0);
        send(1'b1, 1'b0, 26'h1, 1'b0, 5'd0, 8'h42, 1'b0);

        // Idle cycles and malformed characters leave the offset at 1.
        idle(3);
        send(1'b1, 1'b0, 26'h3, 1'b0, 5'd0, 8'h3F, 1'b1);
        send(1'b1, 1'b1, 26'h1, 1'b0, 5'd0, 8'h3F, 1'b1);
        send(1'b1, 1'b0, 26'h1, 1'b0, 5'd0, 8'h43, 1'b0);
        idle(4);

        // Reset with two characters in flight.
        load_key(5'd5);
        send(1'b1, 1'b0, 26'h1, 1'b0, 5'd0, 8'h46, 1'b0);
        send(1'b1, 1'b0, 26'h1, 1'b0, 5'd0, 8'h47, 1'b0);
        rst = 1'b1;
        sb_q.delete();
        #1;
        check_idle("reset_midstream");
        #2;
        rst = 1'b0;
        idle(1);
        check_idle("after_release");
        // Key and offset cleared: A, then B with prog still on.
        send(1'b1, 1'b0, 26'h1, 1'b0, 5'd0, 8'h41, 1'b0);
        send(1'b1, 1'b0, 26'h1, 1'b0, 5'd0, 8'h42, 1'b0);

        // Drain with a bounded wait.
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        idle(1);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d outputs outstanding, want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
